// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the N x N output-stationary systolic MAC array.
package sys_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int unsigned SAT_MAX_W = 128;

    // Full signed product plus headroom for K accumulations.
    function automatic int unsigned acc_width_default(input int unsigned width,
                                                      input int unsigned k);
        return 2 * width + $clog2(k);
    endfunction

    // Clamp a sign-extended accumulator to the signed range of 'width' bits.
    function automatic logic [SAT_MAX_W-1:0] sat_word(input logic signed [SAT_MAX_W-1:0] acc,
                                                      input int unsigned width);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = signed'((SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1));
        lo = ~hi;
        if (acc > hi) begin
            sat_word = hi;
        end else if (acc < lo) begin
            sat_word = lo;
        end else begin
            sat_word = acc;
        end
    endfunction

endpackage

// File: rtl/sys_array_pe.sv
// One processing element: forwards a right and b down through a register each
// and accumulates the signed product on every array step.
module sys_array_pe
    import sys_array_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_step,
    input  logic                 i_clear,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic [ACC_WIDTH-1:0] o_acc
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_WIDTH-1:0]     w_prod_ext;
    logic [WIDTH-1:0]         r_a;
    logic [WIDTH-1:0]         r_b;
    logic [ACC_WIDTH-1:0]     r_acc;

    assign w_prod     = PROD_W'($signed(i_a)) * PROD_W'($signed(i_b));
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // Clear folds into the first step so the tile's first product is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_step) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= i_clear ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/sys_array_nxn.sv
// N x N output-stationary systolic MAC array: C = A*B per tile, rows of C to N FIFOs.
// Define SYS_ARRAY_SATURATE_EN to clamp output words instead of truncating them.
module sys_array_nxn
    import sys_array_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned K         = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = acc_width_default(WIDTH, K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   fifo_a_out_data,
    input  logic [N-1:0]         fifo_a_read_ready,
    output logic [N-1:0]         fifo_a_read_valid,
    input  logic [N*WIDTH-1:0]   fifo_b_out_data,
    input  logic [N-1:0]         fifo_b_read_ready,
    output logic [N-1:0]         fifo_b_read_valid,
    output logic [N*WIDTH-1:0]   fifo_c_in_data,
    output logic [N-1:0]         fifo_c_write_valid,
    input  logic [N-1:0]         fifo_c_write_ready,
    output logic                 busy,
    output logic                 valid
);

    localparam int unsigned CNT_MAX = (K > 2 * N - 1) ? K : 2 * N - 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ROW_W   = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   w_row_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_busy;
    logic               w_step;
    logic               w_clear;
    logic               w_inject;
    logic               w_all_rd;
    logic               w_all_wr;

    logic [WIDTH-1:0]     w_a_h     [N][N];
    logic [WIDTH-1:0]     w_b_v     [N][N];
    logic [WIDTH-1:0]     w_a_fwd   [N][N];
    logic [WIDTH-1:0]     w_b_fwd   [N][N];
    logic [ACC_WIDTH-1:0] w_acc     [N][N];
    logic [WIDTH-1:0]     w_unused_a [N];
    logic [WIDTH-1:0]     w_unused_b [N];
    logic [WIDTH-1:0]     w_c_word  [N];

    assign w_all_rd = (&fifo_a_read_ready) & (&fifo_b_read_ready);
    assign w_all_wr = &fifo_c_write_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_row_nxt          = r_row;
        w_valid_nxt        = r_valid;
        w_step             = 1'b0;
        w_clear            = 1'b0;
        w_inject           = 1'b0;
        fifo_a_read_valid  = '0;
        fifo_b_read_valid  = '0;
        fifo_c_write_valid = '0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (w_all_rd) begin
                    w_step            = 1'b1;
                    w_inject          = 1'b1;
                    w_clear           = (r_cnt == '0);
                    fifo_a_read_valid = '1;
                    fifo_b_read_valid = '1;
                    if (r_cnt == CNT_W'(K - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(2 * N - 2)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_OUTPUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (w_all_wr) begin
                    fifo_c_write_valid = '1;
                    if (r_row == ROW_W'(N - 1)) begin
                        w_row_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy  = r_busy;
    assign valid = r_valid;

    // Input skew: row i / column j delayed by i / j steps; zeros injected in DRAIN.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] w_a_inj;
        logic [WIDTH-1:0] w_b_inj;
        assign w_a_inj = w_inject ? fifo_a_out_data[i*WIDTH +: WIDTH] : '0;
        assign w_b_inj = w_inject ? fifo_b_out_data[i*WIDTH +: WIDTH] : '0;
        if (i == 0) begin : g_nosk
            assign w_a_h[i][0] = w_a_inj;
            assign w_b_v[0][i] = w_b_inj;
        end else begin : g_sk
            logic [WIDTH-1:0] r_sk_a [i];
            logic [WIDTH-1:0] r_sk_b [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int d = 0; d < i; d++) begin
                        r_sk_a[d] <= '0;
                        r_sk_b[d] <= '0;
                    end
                end else if (w_step) begin
                    r_sk_a[0] <= w_a_inj;
                    r_sk_b[0] <= w_b_inj;
                    for (int d = 1; d < i; d++) begin
                        r_sk_a[d] <= r_sk_a[d-1];
                        r_sk_b[d] <= r_sk_b[d-1];
                    end
                end
            end
            assign w_a_h[i][0] = r_sk_a[i-1];
            assign w_b_v[0][i] = r_sk_b[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sys_array_pe #(
                .WIDTH     (WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .i_step  (w_step),
                .i_clear (w_clear),
                .i_a     (w_a_h[i][j]),
                .i_b     (w_b_v[i][j]),
                .o_a     (w_a_fwd[i][j]),
                .o_b     (w_b_fwd[i][j]),
                .o_acc   (w_acc[i][j])
            );
            if (j > 0) begin : g_ah
                assign w_a_h[i][j] = w_a_fwd[i][j-1];
            end
            if (i > 0) begin : g_bv
                assign w_b_v[i][j] = w_b_fwd[i-1][j];
            end
        end
        assign w_unused_a[i] = w_a_fwd[i][N-1];
        assign w_unused_b[i] = w_b_fwd[N-1][i];
    end

    for (genvar j = 0; j < N; j++) begin : g_out
`ifdef SYS_ARRAY_SATURATE_EN
        assign w_c_word[j] = WIDTH'(sat_word(SAT_MAX_W'($signed(w_acc[r_row][j])), WIDTH));
`else
        logic w_unused_hi;
        assign w_unused_hi = ^w_acc[r_row][j][ACC_WIDTH-1:WIDTH];
        assign w_c_word[j] = w_acc[r_row][j][WIDTH-1:0];
`endif
        assign fifo_c_in_data[j*WIDTH +: WIDTH] = w_c_word[j];
    end

endmodule

// File: doc/sys_array_nxn.md
# sys_array_nxn

Parametrised N×N output-stationary systolic multiply-accumulate array computing one C = A·B tile of inner dimension K per job. Streams one A row-stream and one B column-stream per channel from show-ahead input FIFOs and writes C row by row into N output FIFOs. It is the generalised successor of the fixed 2×2 array, adding skew, global stall, signed accumulation and a sticky completion flag.

## Interface
- N, default 2: array dimension; channels per side.
- K, default 4: inner dimension; operands popped per channel per tile.
- WIDTH, default 16: operand and result word width.
- ACC_WIDTH, default 2*WIDTH+$clog2(K): accumulator width.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_a_out_data  input  N*WIDTH  row i operand, slice [i*WIDTH +: WIDTH].
- fifo_a_read_ready  input  N  row i FIFO non-empty; data valid this cycle.
- fifo_a_read_valid  output  N  pop request for row i.
- fifo_b_out_data / fifo_b_read_ready / fifo_b_read_valid: same as the A signals, for column j.
- fifo_c_in_data  output  N*WIDTH  result for output column j.
- fifo_c_write_valid  output  N  push request for column j.
- fifo_c_write_ready  input  N  column j FIFO not full.
- busy  output  1  high in LOAD, DRAIN and OUTPUT.
- valid  output  1  sticky; high once at least one tile has been fully written.

## Operation
- FSM states: IDLE, LOAD, DRAIN, OUTPUT.
- IDLE → LOAD: unconditional on the next cycle.
- LOAD: a step occurs when all 2N read_ready are high.
  - On a step, all 2N read_valid assert together and one word is popped per channel.
  - Otherwise nothing is popped and the array holds.
  - After K steps, go to DRAIN.
- Accumulators clear on the first LOAD step of each tile.
- Skew:
  - Row i and column j pass through i and j skew registers respectively.
  - Each PE forwards a right and b down through one register.
  - Operand k meets PE(i,j) at step k+i+j.
  - Skew and pipe registers advance only on steps.
- DRAIN: steps every cycle with zero operands injected, for 2N-1 cycles, then go to OUTPUT.
- OUTPUT: row counter r runs 0..N-1.
  - When all N write_ready are high, all N write_valid assert together and fifo_c_in_data[j] = C[r][j]; r then increments.
  - Otherwise nothing is written and r holds.
  - After row N-1 is written, valid is set and the FSM goes to IDLE.
- Arithmetic: signed two's complement. acc += a*b, computed as a full 2*WIDTH product sign-extended to ACC_WIDTH, wrapping modulo 2^ACC_WIDTH.
- Without the Configuration macro, the output word is acc[WIDTH-1:0].

## Timing
- Reset values: all read_valid and write_valid 0, busy 0, valid 0. FSM in IDLE; skew, pipe and accumulator registers and r all 0.
- Reset asserted mid-job aborts the tile immediately. Partial results are never written and valid clears.
- read_valid and write_valid are combinational from FSM state and the ready inputs. Pop and push take effect on the same edge.
- Minimum job latency, from leaving IDLE to the last write, is K + (2N-1) + N cycles, e.g. 9 cycles for N=2, K=4.
- A stall in LOAD or OUTPUT extends latency cycle-for-cycle. DRAIN never stalls.
- The first LOAD cycle of the next tile is the cycle after the IDLE cycle; valid stays high across tiles.

## Configuration
- SYS_ARRAY_SATURATE_EN defined: each output word is acc clamped to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The accumulator itself still wraps at ACC_WIDTH.
- Undefined: low-WIDTH-bit truncation.

## Structure
- Package sys_array_pkg holds:
  - the FSM state enum;
  - a localparam function computing the default ACC_WIDTH;
  - the saturate function.
- Sub-module sys_array_pe holds one PE: a and b pipe registers, the accumulator, and step and clear inputs. It is instantiated N² times in a generate loop.

## Test plan
- Basic, N=2, K=4, no stalls:
  - Stimulus: row streams A0=1, A1=2; column streams B0=3, B1=4.
  - Response: fifo_c0 receives 12 then 24; fifo_c1 receives 16 then 32; valid rises after cycle 9.
- Input stall:
  - Stimulus: hold fifo_b_read_ready[1] low for 3 cycles in LOAD.
  - Response: zero pops on every channel during those cycles; results identical to the basic test; latency +3.
- Output backpressure:
  - Stimulus: fifo_c_write_ready[0] low for 2 cycles during OUTPUT.
  - Response: no writes on either column; r holds; same result ordering.
- Signed:
  - Stimulus: N=2, K=4, A=-3, B=5.
  - Response: every word is 16'hFFC4 (-60).
- Overflow, K=1, A=B=300:
  - Without SYS_ARRAY_SATURATE_EN: output 24464.
  - With the macro: output 32767.
- Reset mid-job:
  - Stimulus: assert rst during DRAIN, then release.
  - Response: outputs return to reset values; the next tile with the basic data gives 12/16/24/32; valid stays 0 until that tile completes.
